// File: rtl/pulse_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pulse_tx_fifo
// Purpose  : Queues 32-bit pulse heights and serialises them LSB-first onto
//            an FT245-style parallel USB FIFO bus (wr strobe, txe handshake).
// Options  : define PULSE_TX_HEADER_EN to prefix every frame with HEADER_BYTE
// Revision : 1.0 - initial release
// ============================================================================
module pulse_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2
`ifdef PULSE_TX_HEADER_EN
  , parameter logic [7:0] HEADER_BYTE = 8'hA5
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                pulse_height,
  input  logic                       ready,
  input  logic                       txe,
  output logic                       wr,
  output logic                       rd,
  output logic [7:0]                 data_out,
  output logic                       data_oe,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 16;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
`ifdef PULSE_TX_HEADER_EN
  localparam int IW = 3;
  localparam logic [IW-1:0] LAST_IDX = 3'd4;
`else
  localparam int IW = 2;
  localparam logic [IW-1:0] LAST_IDX = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  // Frame byte k: optional header first, then data bytes LSB first.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [IW-1:0] idx);
    logic [7:0] b;
    b = w[7:0];
`ifdef PULSE_TX_HEADER_EN
    case (idx)
      3'd0:    b = HEADER_BYTE;
      3'd1:    b = w[7:0];
      3'd2:    b = w[15:8];
      3'd3:    b = w[23:16];
      default: b = w[31:24];
    endcase
`else
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
`endif
    return b;
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic [15:0]   drop_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    dout_q, dout_d;
  logic          wr_q, oe_q, busy_q;

  logic          full, pop, push_ok, drop;
  logic [IW-1:0] next_idx;
  logic [31:0]   head_word;

  assign full      = (level_q == FULL_LVL);
  assign pop       = (state_q == S_IDLE) && (level_q != '0) && !txe;
  // A full FIFO still accepts a push when the same edge pops a word.
  assign push_ok   = ready && (!full || pop);
  assign drop      = ready && full && !pop;
  assign next_idx  = idx_q + 1'b1;
  assign head_word = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= pulse_height;
    end
  end

  // Pointers, fill level and drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Serialiser state register and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      wr_q    <= (state_d != S_STROBE);
      oe_q    <= (state_d != S_IDLE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state logic: txe only gates progress in IDLE, RELEASE and WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    word_d  = word_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          word_d  = head_word;
          idx_d   = '0;
          dout_d  = sel_byte(head_word, '0);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else if (!txe) begin
          idx_d   = next_idx;
          dout_d  = sel_byte(word_q, next_idx);
          state_d = S_SETUP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (!txe) begin
          idx_d   = next_idx;
          dout_d  = sel_byte(word_q, next_idx);
          state_d = S_SETUP;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign wr         = wr_q;
  assign rd         = 1'b1;
  assign data_out   = dout_q;
  assign data_oe    = oe_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_tx_fifo
// Purpose  : Directed bench for pulse_tx_fifo with a queue-based bus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_tx_fifo;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int T     = 2;
  localparam int P     = S + T + 1;
`ifdef PULSE_TX_HEADER_EN
  localparam logic [7:0] HDR = 8'hA5;
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif
  localparam int HOFF = FB - 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pulse_height = '0;
  logic        ready = 1'b0;
  logic        txe = 1'b1;
  logic        wr, rd, data_oe, overflow, busy;
  logic [7:0]  data_out;
  logic [2:0]  level;
  logic [15:0] drop_count;

  pulse_tx_fifo #(.DEPTH(DEPTH), .SETUP_CYC(S), .STROBE_CYC(T)) dut (
    .clk(clk), .rst(rst), .pulse_height(pulse_height), .ready(ready), .txe(txe),
    .wr(wr), .rd(rd), .data_out(data_out), .data_oe(data_oe), .level(level),
    .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [31:0] w, input int k);
    int j;
    j = k;
`ifdef PULSE_TX_HEADER_EN
    if (j == 0) return HDR;
    j = j - 1;
`endif
    return w[8*j +: 8];
  endfunction

  // ---------------- behavioural model ----------------
  // Words wait in mq; the current frame's remaining bytes sit in mb.
  // ph is the cycle offset inside the current byte (0..P-1), -1 when none.
  logic [31:0] mq[$];
  logic [7:0]  mb[$];
  int          ph = -1;
  bit          mwait = 1'b0;
  logic [7:0]  mcur = '0;
  bit          movf = 1'b0;
  logic [15:0] mdrop = '0;
  bit          mstarted = 1'b0;
  logic [31:0] mw;

  always @(posedge clk) begin
    cyc++;
    mstarted = 1'b1;
    if (rst) begin
      mq.delete(); mb.delete();
      ph = -1; mwait = 1'b0; mcur = '0; movf = 1'b0; mdrop = '0;
    end else begin
      if (ph < 0 && !mwait) begin
        if (mq.size() > 0 && !txe) begin
          mw = mq.pop_front();
          mb.delete();
          for (int k = 0; k < FB; k++) mb.push_back(frame_byte(mw, k));
          mcur = mb.pop_front();
          ph = 0;
        end
      end else if (mwait) begin
        if (!txe) begin mcur = mb.pop_front(); ph = 0; mwait = 1'b0; end
      end else if (ph == P - 1) begin
        if (mb.size() == 0) ph = -1;
        else if (!txe) begin mcur = mb.pop_front(); ph = 0; end
        else begin ph = -1; mwait = 1'b1; end
      end else begin
        ph++;
      end
      if (ready) begin
        if (mq.size() < DEPTH) mq.push_back(pulse_height);
        else begin
          movf = 1'b1;
          if (mdrop != 16'hFFFF) mdrop++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (mstarted) begin
      chk("m_wr",    wr,         ((ph >= S) && (ph < S + T)) ? 1'b0 : 1'b1);
      chk("m_oe",    data_oe,    ((ph >= 0) || mwait) ? 1'b1 : 1'b0);
      chk("m_busy",  busy,       ((ph >= 0) || mwait) ? 1'b1 : 1'b0);
      chk("m_data",  data_out,   mcur);
      chk("m_level", level,      mq.size());
      chk("m_ovf",   overflow,   movf);
      chk("m_drop",  drop_count, mdrop);
      chk("m_rd",    rd,         1'b1);
    end
  end

  // Byte capture at each falling edge of wr.
  logic [7:0] sb[$];
  int         sc[$];
  logic       prev_wr = 1'b1;
  always @(negedge clk) begin
    if (prev_wr && !wr) begin
      sb.push_back(data_out);
      sc.push_back(cyc);
    end
    prev_wr = wr;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    pulse_height = w;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  int n0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_wr", wr, 1'b1);
    chk("rst_oe", data_oe, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    tick(2);

    // Single word, txe low
    txe = 1'b0;
    sb.delete(); sc.delete();
    push(32'h12345678);
    n0 = cyc;
    chk("t1_level_after_push", level, 1);
    tick(30);
    chk("t1_nbytes", sb.size(), FB);
    if (sb.size() == FB) begin
      chk("t1_b0", sb[HOFF+0], 8'h78);
      chk("t1_b1", sb[HOFF+1], 8'h56);
      chk("t1_b2", sb[HOFF+2], 8'h34);
      chk("t1_b3", sb[HOFF+3], 8'h12);
      chk("t1_first_wr_low", sc[0] - n0, 1 + S);
      chk("t1_byte_period", sc[1] - sc[0], P);
    end
    chk("t1_idle", busy, 1'b0);

    // Overflow with txe high
    txe = 1'b1;
    for (int i = 1; i <= 6; i++) push(i);
    tick(1);
    chk("ov_level", level, 4);
    chk("ov_flag", overflow, 1'b1);
    chk("ov_drop", drop_count, 2);
    sb.delete();
    txe = 1'b0;
    tick(4 * FB * P + 10);
    chk("ov_nbytes", sb.size(), 4 * FB);
    if (sb.size() == 4 * FB)
      for (int k = 0; k < 4; k++) chk("ov_word_order", sb[k*FB + HOFF], k + 1);

    // Push while full on the pop cycle
    txe = 1'b1;
    for (int i = 10; i < 14; i++) push(i);
    chk("pf_full", level, 4);
    sb.delete();
    txe = 1'b0;
    push(14);
    chk("pf_level", level, 4);
    chk("pf_nodrop", drop_count, 2);
    tick(5 * FB * P + 10);
    chk("pf_nbytes", sb.size(), 5 * FB);
    if (sb.size() == 5 * FB)
      for (int k = 0; k < 5; k++) chk("pf_word_order", sb[k*FB + HOFF], 10 + k);

    // txe stall during the second byte's strobe
    sb.delete();
    push(32'hAABBCCDD);
    tick(8);
    txe = 1'b1;
    tick(6);
    chk("st_nbytes", sb.size(), 2);
    chk("st_hold", data_out, frame_byte(32'hAABBCCDD, 1));
    chk("st_wr", wr, 1'b1);
    chk("st_oe", data_oe, 1'b1);
    txe = 1'b0;
    tick(30);
    chk("st_total", sb.size(), FB);
    if (sb.size() == FB) chk("st_last", sb[FB-1], 8'hAA);

    // Reset during the third byte's setup
    sb.delete();
    push(32'h01020304);
    tick(11);
    rst = 1'b1;
    tick(1);
    chk("mr_wr", wr, 1'b1);
    chk("mr_oe", data_oe, 1'b0);
    chk("mr_level", level, 0);
    rst = 1'b0;
    tick(20);
    chk("mr_no_more", sb.size(), 2);

    // Frame content for DEADBEEF
    sb.delete();
    push(32'hDEADBEEF);
    tick(30);
    chk("db_nbytes", sb.size(), FB);
    if (sb.size() == FB) begin
`ifdef PULSE_TX_HEADER_EN
      chk("db_hdr", sb[0], 8'hA5);
`endif
      chk("db_b0", sb[HOFF+0], 8'hEF);
      chk("db_b1", sb[HOFF+1], 8'hBE);
      chk("db_b2", sb[HOFF+2], 8'hAD);
      chk("db_b3", sb[HOFF+3], 8'hDE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
